// File: rtl/r16_serial_sub.sv
// Digit-serial subtractor: y = a - b - bin, one DIGIT-wide slice per clock, LSB first,
// with the slice carry registered between steps and a start/busy/done handshake.
module r16_serial_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] y,
  output logic             bout,
  output logic             v,
  output logic             busy,
  output logic             done
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    step_q, step_d;
  logic             c_q, c_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic [DIGIT-1:0] a_sl, b_sl;
  logic [DIGIT-1:0] lo_sum;
  logic [1:0]       msb_sum;
  logic [DIGIT-1:0] slice_sum;
  logic             c_msb, c_out;

  // Subtraction as a + ~b + c; the low bits are summed apart so the carry into
  // the slice MSB is available for the signed-overflow flag.
  always_comb begin
    a_sl      = a_q[step_q*DIGIT +: DIGIT];
    b_sl      = ~b_q[step_q*DIGIT +: DIGIT];
    lo_sum    = {1'b0, a_sl[DIGIT-2:0]} + {1'b0, b_sl[DIGIT-2:0]}
              + {{(DIGIT-1){1'b0}}, c_q};
    c_msb     = lo_sum[DIGIT-1];
    msb_sum   = {1'b0, a_sl[DIGIT-1]} + {1'b0, b_sl[DIGIT-1]} + {1'b0, c_msb};
    c_out     = msb_sum[1];
    slice_sum = {msb_sum[0], lo_sum[DIGIT-2:0]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    step_d  = step_q;
    c_d     = c_q;
    bout_d  = bout_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          c_d     = ~bin;
          step_d  = '0;
          y_d     = '0;
          bout_d  = 1'b0;
          v_d     = 1'b0;
        end
      end
      ST_RUN: begin
        y_d[step_q*DIGIT +: DIGIT] = slice_sum;
        c_d = c_out;
        if (step_q == LAST_STEP) begin
          state_d = ST_DONE;
          bout_d  = ~c_out;
          v_d     = c_msb ^ c_out;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      step_q  <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      step_q  <= step_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign y    = y_q;
  assign bout = bout_q;
  assign v    = v_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_r16_serial_sub.sv
// Bench for r16_serial_sub: vector table plus hand sequences for held start and
// mid-operation reset; results are checked through an expected queue on done.
module tb_r16_serial_sub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        bin;
  logic [15:0] y;
  logic        bout, v, busy, done;

  logic [17:0] exp_q[$];   // {v, bout, y}
  int n_checks;
  int n_fail;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] ey;
    logic        eb;
    logic        ev;
  } vec_t;

  vec_t vecs[6];

  r16_serial_sub dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .y    (y),
    .bout (bout),
    .v    (v),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mbin);
    logic [16:0] d;
    logic        ov;
    d  = {1'b0, ma} - {1'b0, mb} - {16'b0, mbin};
    ov = (ma[15] != mb[15]) && (d[15] != ma[15]);
    return {ov, d[16], d[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_result();
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL result: done seen with empty expected queue (y=0x%0h)", y);
    end else begin
      e = exp_q.pop_front();
      check("y", {16'b0, y}, {16'b0, e[15:0]});
      check("bout", {31'b0, bout}, {31'b0, e[16]});
      check("v", {31'b0, v}, {31'b0, e[17]});
    end
  endtask

  task automatic run_op(input logic [15:0] pa, input logic [15:0] pb, input logic pbin,
                        input logic [17:0] e);
    int cyc;
    int bcnt;
    bit seen;
    @(negedge clk);
    a = pa; b = pb; bin = pbin; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom_range(0, 1));
    cyc = 0; bcnt = 0; seen = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("y_cleared_on_accept", {16'b0, y}, 32'h0);
      if (busy) bcnt++;
      if (done) begin
        seen = 1;
        check("busy_low_in_done", {31'b0, busy}, 32'h0);
        check_result();
      end
    end
    check("done_latency", cyc, 5);
    check("busy_cycles", bcnt, 4);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    logic [15:0] ta, tbv;
    logic        tbin;
    int          ndone;

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_y", {16'b0, y}, 32'h0);
    check("rst_bout", {31'b0, bout}, 32'h0);
    check("rst_v", {31'b0, v}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].ev, vecs[i].eb, vecs[i].ey});

    // Result holds in IDLE while start stays low
    repeat (3) @(negedge clk);
    check("idle_hold_y", {16'b0, y}, {16'b0, vecs[5].ey});
    check("idle_busy", {31'b0, busy}, 32'h0);

    // Borrow boundary sweep
    for (int k = 0; k < 32; k++) begin
      ta   = {3'b0, k[3], 3'b0, k[2], 3'b0, k[1], 3'b0, k[0]};
      tbin = k[4];
      run_op(ta, 16'h1111, tbin, model(ta, 16'h1111, tbin));
    end

    for (int k = 0; k < 8; k++) begin
      ta = 16'($urandom); tbv = 16'($urandom); tbin = 1'($urandom_range(0, 1));
      run_op(ta, tbv, tbin, model(ta, tbv, tbin));
    end

    // start held high, operands changing every cycle: accepts at cycles 0, 6, 12
    ndone = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i % 6 == 5) begin
        check("held_done", {31'b0, done}, 32'h1);
        if (done) begin
          ndone++;
          check_result();
        end
      end else begin
        check("held_no_done", {31'b0, done}, 32'h0);
      end
      start = 1'b1;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom_range(0, 1));
      if (i % 6 == 0) exp_q.push_back(model(a, b, bin));
    end
    @(negedge clk);
    start = 1'b0;
    check("held_done_count", ndone, 3);
    check("queue_empty", exp_q.size(), 0);

    // Reset during the second RUN cycle, then a fresh operation
    @(negedge clk);
    a = 16'h5555; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_y", {16'b0, y}, 32'h0);
    check("midrun_rst_busy", {31'b0, busy}, 32'h0);
    check("midrun_rst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b0, 16'hFFFE});
    check("queue_empty_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
